// File: rtl/btn_ctrl_unit.sv
// Button control unit: turns debounced button levels into stopwatch run/clear
// control and watch-set field select / increment / decrement pulses, with
// press-and-hold auto-repeat on the up and down buttons.
//
// Stopwatch FSM states
//   state    | meaning
//   ST_STOP  | stopwatch halted, o_sw_run = 0
//   ST_RUN   | stopwatch counting, o_sw_run = 1 (kept in either mode)
//   ST_CLEAR | single-cycle clear pulse, returns to ST_STOP
module btn_ctrl_unit #(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_mode,
  input  logic       i_btn_r,
  input  logic       i_btn_l,
  input  logic       i_btn_u,
  input  logic       i_btn_d,
  output logic       o_sw_run,
  output logic       o_sw_clear,
  output logic [1:0] o_wt_sel,
  output logic       o_wt_inc,
  output logic       o_wt_dec,
  output logic       o_mode
);

  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW:0] HOLD_T = (CW + 1)'(HOLD_CYC);
  localparam logic [CW:0] REP_T  = (CW + 1)'(REPEAT_CYC);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  // button vector bit order: 0 = r, 1 = l, 2 = u, 3 = d
  logic [3:0] btn_in;
  logic [3:0] btn_q;
  logic [3:0] btn_p;
  logic [3:0] rise;
  logic       armed;
  logic       sync1;

  logic       mode_chg;
  logic       sw_act;
  logic       wt_act;
  logic       both_ud;
  logic       hold_en;
  logic [1:0] held;

  logic [1:0][CW-1:0] cnt_q;
  logic [1:0][CW-1:0] cnt_d;
  logic [1:0][CW:0]   cnt_inc;
  logic [1:0][CW:0]   target;
  logic [1:0]         rep_q;
  logic [1:0]         rep_d;
  logic [1:0]         fire;

  logic [1:0] state;
  logic [1:0] state_d;
  logic [1:0] sel_d;
  logic       inc_d;
  logic       dec_d;

  assign btn_in = {i_btn_d, i_btn_u, i_btn_l, i_btn_r};

  // Two-flop synchronizer for the asynchronous mode switch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      o_mode <= 1'b0;
    end else begin
      sync1  <= sw_mode;
      o_mode <= sync1;
    end
  end

  // Button sampling; on the first clock after reset the previous-sample
  // register takes the live input so a button already held shows no rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q <= '0;
      btn_p <= '0;
      armed <= 1'b0;
    end else begin
      btn_q <= btn_in;
      btn_p <= armed ? btn_q : btn_in;
      armed <= 1'b1;
    end
  end

  assign rise     = btn_q & ~btn_p;
  assign mode_chg = sync1 ^ o_mode;
  assign sw_act   = ~o_mode & ~mode_chg;
  assign wt_act   = o_mode & ~mode_chg;
  assign both_ud  = btn_q[2] & btn_q[3];
  assign hold_en  = wt_act & ~both_ud;
  assign held     = {btn_q[3], btn_q[2]};

  // Hold/repeat counters for u (index 0) and d (index 1): count to HOLD_CYC
  // for the first repeat, then to REPEAT_CYC for each following one
  always_comb begin
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    fire    = '0;
    cnt_inc = '0;
    target  = '0;
    for (int i = 0; i < 2; i++) begin
      cnt_inc[i] = {1'b0, cnt_q[i]} + 1'b1;
      target[i]  = rep_q[i] ? REP_T : HOLD_T;
      if (!hold_en || !held[i]) begin
        cnt_d[i] = '0;
        rep_d[i] = 1'b0;
      end else if (cnt_inc[i] >= target[i]) begin
        cnt_d[i] = '0;
        rep_d[i] = 1'b1;
        fire[i]  = 1'b1;
      end else if (cnt_q[i] != '1) begin
        cnt_d[i] = cnt_inc[i][CW-1:0];
      end
    end
  end

  // Stopwatch next state; r wins over l when both rise together
  always_comb begin
    state_d = state;
    case (state)
      ST_STOP: begin
        if (sw_act && rise[0])      state_d = ST_RUN;
        else if (sw_act && rise[1]) state_d = ST_CLEAR;
      end
      ST_RUN: begin
        if (sw_act && rise[0]) state_d = ST_STOP;
      end
      ST_CLEAR: state_d = ST_STOP;
      default:  state_d = ST_STOP;
    endcase
  end

  // Watch field select and inc/dec pulse generation
  always_comb begin
    sel_d = (o_wt_sel == 2'd3) ? 2'd0 : o_wt_sel;
    if (wt_act && rise[0] && !rise[1]) begin
      sel_d = (o_wt_sel >= 2'd2) ? 2'd0 : o_wt_sel + 2'd1;
    end else if (wt_act && rise[1] && !rise[0]) begin
      sel_d = (o_wt_sel == 2'd0 || o_wt_sel == 2'd3) ? 2'd2 : o_wt_sel - 2'd1;
    end
    inc_d = wt_act & ~both_ud & (rise[2] | fire[0]);
    dec_d = wt_act & ~both_ud & (rise[3] | fire[1]);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_STOP;
      o_sw_run   <= 1'b0;
      o_sw_clear <= 1'b0;
      o_wt_sel   <= 2'd0;
      o_wt_inc   <= 1'b0;
      o_wt_dec   <= 1'b0;
      cnt_q      <= '0;
      rep_q      <= '0;
    end else begin
      state      <= state_d;
      o_sw_run   <= (state_d == ST_RUN);
      o_sw_clear <= (state_d == ST_CLEAR);
      o_wt_sel   <= sel_d;
      o_wt_inc   <= inc_d;
      o_wt_dec   <= dec_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
    end
  end

endmodule

// File: doc/btn_ctrl_unit.md
BTN_CTRL_UNIT -- requirements
Module: btn_ctrl_unit

Interface
REQ-001 Parameters SHALL be:
  - HOLD_CYC, default 50_000_000, is the number of cycles a held up/down button must stay high before auto-repeat starts.
  - REPEAT_CYC, default 10_000_000, is the number of cycles between auto-repeat pulses.
REQ-002 Ports SHALL be:
  - clk  in  1  system clock
  - rst  in  1  asynchronous active-high reset
  - sw_mode  in  1  mode switch, 0 = stopwatch, 1 = watch-set; asynchronous to clk
  - i_btn_r  in  1  debounced run/stop / field-right level
  - i_btn_l  in  1  debounced clear / field-left level
  - i_btn_u  in  1  debounced up level
  - i_btn_d  in  1  debounced down level
  - o_sw_run  out  1  stopwatch counting enable (level)
  - o_sw_clear  out  1  stopwatch clear, 1-cycle pulse
  - o_wt_sel  out  2  watch field being set: 0 = sec, 1 = min, 2 = hour
  - o_wt_inc  out  1  increment selected field, 1-cycle pulse
  - o_wt_dec  out  1  decrement selected field, 1-cycle pulse
  - o_mode  out  1  synchronized mode
REQ-003 The block SHALL use one clock, clk; rst SHALL be asynchronous and active-high.

Function
REQ-004 sw_mode SHALL pass through a 2-flop synchronizer; o_mode SHALL be the second flop.
REQ-005 Each i_btn_* SHALL be registered once; a rise SHALL be that register being 1 while the previous sample was 0.
REQ-006 All outputs SHALL be registered; a pulse SHALL appear in the cycle after the rise is detected, i.e. 2 cycles after the input goes high.
REQ-007 The stopwatch FSM SHALL have states STOP, RUN and CLEAR, and SHALL act on buttons only when o_mode=0.
REQ-008 FSM transitions SHALL be:
  - STOP: r-rise goes to RUN; l-rise goes to CLEAR; r and l rising in the same cycle go to RUN (r has priority).
  - RUN: r-rise goes to STOP; l ignored.
  - CLEAR: lasts exactly 1 cycle, then goes to STOP.
REQ-009 o_sw_run SHALL be 1 exactly while the state is RUN; o_sw_clear SHALL be 1 exactly while the state is CLEAR.
REQ-010 The stopwatch state SHALL be kept across mode changes: RUN continues counting while o_mode=1.
REQ-011 With o_mode=1, field selection SHALL work as follows:
  - r-rise: o_wt_sel goes 0→1→2→0.
  - l-rise: o_wt_sel goes 0→2→1→0.
  - r and l rising in the same cycle: no change.
  - o_wt_sel never takes the value 3.
REQ-012 With o_mode=1, a u-rise SHALL produce one o_wt_inc pulse and a d-rise one o_wt_dec pulse.
REQ-013 Each of u and d SHALL have a hold counter that runs while its button is high.
  - When the counter reaches HOLD_CYC, a repeat pulse SHALL fire.
  - Further pulses SHALL fire every REPEAT_CYC cycles until release.
  - Release SHALL clear the counter immediately, with no pulse on release.
REQ-014 If u and d are both high, both counters SHALL be cleared and no inc/dec pulse issued; o_wt_inc and o_wt_dec SHALL never be high together.
REQ-015 Counter width SHALL be clog2(max(HOLD_CYC, REPEAT_CYC)+1); counters SHALL saturate rather than wrap.
REQ-016 When o_mode changes, hold counters SHALL clear, and u/d/r/l rises SHALL be ignored for the cycle in which o_mode changes.
REQ-017 With o_mode=0, u and d SHALL be ignored and their counters held at 0.

Reset
REQ-018 While rst=1, the block SHALL hold:
  - FSM in STOP, o_sw_run=0, o_sw_clear=0
  - o_wt_sel=0, o_wt_inc=0, o_wt_dec=0
  - synchronizer flops, o_mode, button registers and counters all 0
REQ-019 Reset asserted mid-RUN or mid-repeat SHALL force reset values immediately, without waiting for clk.
REQ-020 After reset release, a button already high SHALL produce no rise until it is released and pressed again, because the button registers reset to 0 are loaded with 1 on the first clock.

Verification (HOLD_CYC=8, REPEAT_CYC=4)
REQ-021 Bench SHALL cover:
  - mode 0; r pulse high 3 cycles → o_sw_run=1 two cycles after r rises; second r press → o_sw_run=0.
  - STOP; l press → o_sw_clear high exactly 1 cycle, o_sw_run stays 0; l pressed in RUN → no clear.
  - mode 1; r pressed 4 times → o_wt_sel sequence 1,2,0,1; then l pressed twice → 0,2.
  - mode 1; u held 20 cycles → o_wt_inc pulses at the press, at hold count 8, then at 12, 16 and 20 (5 pulses); u and d held together → no pulses.
  - RUN, switch to mode 1 for 50 cycles and back → o_sw_run stays 1 throughout; u presses in mode 0 → no o_wt_inc.
  - rst asserted between clock edges during RUN with u held → all outputs 0 immediately; u still held after release → no pulse.
